// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush sequencer.
// State encodings double as the externally visible ctrl_state value.
package pipeline_ctrl_pkg;

  localparam logic [1:0] CTRL_BOOT     = 2'd0;
  localparam logic [1:0] CTRL_RUN      = 2'd1;
  localparam logic [1:0] CTRL_MEM_WAIT = 2'd2;
  localparam logic [1:0] CTRL_HALT     = 2'd3;

  // One bundle of stage controls, decoded together each cycle.
  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic id_ex_we;
    logic ex_mem_we;
    logic mem_wb_we;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
    logic npc_redirect;
  } ctrl_t;

endpackage

// File: rtl/pipeline_ctrl_wait_timer.sv
// Counts consecutive data-memory busy cycles and flags when the next busy
// cycle would be the WAIT_MAX-th one.
module pipe_wait_timer
  import pipeline_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_start,
  input  logic i_inc,
  output logic o_expire
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  logic [CW-1:0] r_wait_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (i_clr) begin
      r_wait_cnt <= '0;
    end else if (i_start) begin
      r_wait_cnt <= CW'(1);
    end else if (i_inc) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign o_expire = (r_wait_cnt == CW'(WAIT_MAX - 1));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline; Mealy decode of state+inputs.
// Optional performance counters are enabled with `define PIPE_PERF_CNT_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int WAIT_MAX    = 16
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst_n,
  input  logic        load_stall,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_br_target,
  input  logic        dram_busy,
  input  logic        halt_clr,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        id_ex_we,
  output logic        ex_mem_we,
  output logic        mem_wb_we,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_wb_flush,
  output logic        npc_redirect,
  output logic [31:0] npc_target,
  output logic [1:0]  ctrl_state,
  output logic        wait_timeout
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [BW-1:0] r_boot_cnt;
  logic          r_timeout;
  logic          w_active;
  logic          w_freeze;
  logic          w_redirect;
  logic          w_load;
  logic          w_expire;
  logic          w_wait_clr;
  logic          w_wait_start;
  logic          w_wait_inc;
  ctrl_t         w_ctrl;

  assign w_active   = (r_state == CTRL_RUN) || (r_state == CTRL_MEM_WAIT);
  assign w_freeze   = w_active & dram_busy;
  // A redirect seen during a freeze is simply re-presented by the frozen EX stage.
  assign w_redirect = w_active & ~dram_busy & ex_br_taken;
  assign w_load     = w_active & ~dram_busy & ~ex_br_taken & load_stall;

  // NOTE: every combinational output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_ctrl = '0;
    if (r_state == CTRL_BOOT) begin
      w_ctrl.if_id_flush  = 1'b1;
      w_ctrl.id_ex_flush  = 1'b1;
      w_ctrl.mem_wb_flush = 1'b1;
    end else if (w_freeze) begin
      w_ctrl.mem_wb_flush = 1'b1;
    end else if (w_redirect) begin
      w_ctrl.pc_we        = 1'b1;
      w_ctrl.if_id_we     = 1'b1;
      w_ctrl.id_ex_we     = 1'b1;
      w_ctrl.ex_mem_we    = 1'b1;
      w_ctrl.mem_wb_we    = 1'b1;
      w_ctrl.npc_redirect = 1'b1;
      w_ctrl.if_id_flush  = 1'b1;
      w_ctrl.id_ex_flush  = 1'b1;
    end else if (w_load) begin
      w_ctrl.id_ex_we     = 1'b1;
      w_ctrl.ex_mem_we    = 1'b1;
      w_ctrl.mem_wb_we    = 1'b1;
      w_ctrl.id_ex_flush  = 1'b1;
    end else if (w_active) begin
      w_ctrl.pc_we        = 1'b1;
      w_ctrl.if_id_we     = 1'b1;
      w_ctrl.id_ex_we     = 1'b1;
      w_ctrl.ex_mem_we    = 1'b1;
      w_ctrl.mem_wb_we    = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_wait_clr   = 1'b0;
    w_wait_start = 1'b0;
    w_wait_inc   = 1'b0;
    case (r_state)
      CTRL_BOOT: begin
        if (r_boot_cnt == '0) begin
          w_state_nxt = CTRL_RUN;
          w_wait_clr  = 1'b1;
        end
      end
      CTRL_RUN: begin
        if (dram_busy) begin
          w_state_nxt  = CTRL_MEM_WAIT;
          w_wait_start = 1'b1;
        end
      end
      CTRL_MEM_WAIT: begin
        if (!dram_busy) begin
          w_state_nxt = CTRL_RUN;
          w_wait_clr  = 1'b1;
        end else if (w_expire) begin
          w_state_nxt = CTRL_HALT;
        end else begin
          w_wait_inc  = 1'b1;
        end
      end
      default: begin
        if (halt_clr) w_state_nxt = CTRL_BOOT;
      end
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_state    <= CTRL_BOOT;
      r_boot_cnt <= BW'(BOOT_CYCLES - 1);
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CTRL_BOOT && r_boot_cnt != '0) begin
        r_boot_cnt <= r_boot_cnt - 1'b1;
      end else if (r_state == CTRL_HALT && halt_clr) begin
        r_boot_cnt <= BW'(BOOT_CYCLES - 1);
      end
      if (r_state == CTRL_MEM_WAIT && dram_busy && w_expire) begin
        r_timeout <= 1'b1;
      end
    end
  end

  pipe_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk      (cpu_clk),
    .rst_n    (cpu_rst_n),
    .i_clr    (w_wait_clr),
    .i_start  (w_wait_start),
    .i_inc    (w_wait_inc),
    .o_expire (w_expire)
  );

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if ((w_freeze || w_load) && perf_stall_cnt != 32'hFFFF_FFFF) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (w_redirect && perf_flush_cnt != 32'hFFFF_FFFF) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

  assign pc_we        = w_ctrl.pc_we;
  assign if_id_we     = w_ctrl.if_id_we;
  assign id_ex_we     = w_ctrl.id_ex_we;
  assign ex_mem_we    = w_ctrl.ex_mem_we;
  assign mem_wb_we    = w_ctrl.mem_wb_we;
  assign if_id_flush  = w_ctrl.if_id_flush;
  assign id_ex_flush  = w_ctrl.id_ex_flush;
  assign mem_wb_flush = w_ctrl.mem_wb_flush;
  assign npc_redirect = w_ctrl.npc_redirect;
  assign npc_target   = w_ctrl.npc_redirect ? ex_br_target : 32'd0;
  assign ctrl_state   = r_state;
  assign wait_timeout = r_timeout;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized self-checking bench for pipeline_ctrl against a cycle-level
// behavioural model of the sequencer rules (boot length, busy-run length, halts).
module tb_pipeline_ctrl;

  localparam int BOOT_CYCLES = 2;
  localparam int WAIT_MAX    = 16;

  localparam int M_BOOT = 0, M_RUN = 1, M_WAIT = 2, M_HALT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_stall, ex_br_taken, dram_busy, halt_clr;
  logic [31:0] ex_br_target;
  logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic        if_id_flush, id_ex_flush, mem_wb_flush, npc_redirect;
  logic [31:0] npc_target;
  logic [1:0]  ctrl_state;
  logic        wait_timeout;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Model: mode, cycles spent in boot, length of the current busy run, sticky timeout.
  int          m_mode;
  int          m_boot_elapsed;
  int          m_busy_run;
  logic        m_timeout;
  logic [31:0] m_stall_cnt, m_flush_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .BOOT_CYCLES (BOOT_CYCLES),
    .WAIT_MAX    (WAIT_MAX)
  ) dut (
    .cpu_clk      (clk),
    .cpu_rst_n    (rst_n),
    .load_stall   (load_stall),
    .ex_br_taken  (ex_br_taken),
    .ex_br_target (ex_br_target),
    .dram_busy    (dram_busy),
    .halt_clr     (halt_clr),
    .pc_we        (pc_we),
    .if_id_we     (if_id_we),
    .id_ex_we     (id_ex_we),
    .ex_mem_we    (ex_mem_we),
    .mem_wb_we    (mem_wb_we),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .mem_wb_flush (mem_wb_flush),
    .npc_redirect (npc_redirect),
    .npc_target   (npc_target),
    .ctrl_state   (ctrl_state),
    .wait_timeout (wait_timeout)
`ifdef PIPE_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode         = M_BOOT;
    m_boot_elapsed = 0;
    m_busy_run     = 0;
    m_timeout      = 1'b0;
    m_stall_cnt    = '0;
    m_flush_cnt    = '0;
  endtask

  // Expected controls, bit order {pc,if_id,id_ex,ex_mem,mem_wb we; if_id,id_ex,mem_wb flush; redirect}.
  task automatic check_outputs();
    logic [8:0]  exp_v;
    logic [8:0]  mask;
    logic [8:0]  obs_v;
    logic [31:0] exp_tgt;
    exp_v = 9'b0;
    mask  = 9'h1FF;
    if (m_mode == M_BOOT)      exp_v = 9'b00000_111_0;
    else if (m_mode == M_HALT) exp_v = 9'b00000_000_0;
    else if (dram_busy)        exp_v = 9'b00000_001_0;
    else if (ex_br_taken)      exp_v = 9'b11111_110_1;
    else if (load_stall) begin
      exp_v = 9'b00011_010_0;
      mask  = 9'h1BF;  // id_ex_we is irrelevant while id_ex_flush is forced
    end else                   exp_v = 9'b11111_000_0;
    exp_tgt = exp_v[0] ? ex_br_target : 32'd0;
    obs_v = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
             if_id_flush, id_ex_flush, mem_wb_flush, npc_redirect};
    check("ctrl_vec", 32'(obs_v & mask), 32'(exp_v & mask));
    check("npc_target", npc_target, exp_tgt);
    check("ctrl_state", 32'(ctrl_state), 32'(m_mode));
    check("wait_timeout", 32'(wait_timeout), 32'(m_timeout));
`ifdef PIPE_PERF_CNT_EN
    check("perf_stall_cnt", perf_stall_cnt, m_stall_cnt);
    check("perf_flush_cnt", perf_flush_cnt, m_flush_cnt);
`endif
  endtask

  task automatic model_update();
    bit active;
    active = (m_mode == M_RUN) || (m_mode == M_WAIT);
    if (active && (dram_busy || (!ex_br_taken && load_stall)) && m_stall_cnt != 32'hFFFF_FFFF)
      m_stall_cnt++;
    if (active && !dram_busy && ex_br_taken && m_flush_cnt != 32'hFFFF_FFFF)
      m_flush_cnt++;
    case (m_mode)
      M_BOOT: begin
        m_boot_elapsed++;
        if (m_boot_elapsed == BOOT_CYCLES) begin
          m_mode     = M_RUN;
          m_busy_run = 0;
        end
      end
      M_RUN, M_WAIT: begin
        if (dram_busy) begin
          m_busy_run++;
          if (m_busy_run == WAIT_MAX) begin
            m_mode    = M_HALT;
            m_timeout = 1'b1;
          end else begin
            m_mode = M_WAIT;
          end
        end else begin
          m_mode     = M_RUN;
          m_busy_run = 0;
        end
      end
      default: begin
        if (halt_clr) begin
          m_mode         = M_BOOT;
          m_boot_elapsed = 0;
        end
      end
    endcase
  endtask

  task automatic drive(input logic ls, input logic br, input logic [31:0] tgt,
                       input logic busy, input logic hc);
    load_stall   = ls;
    ex_br_taken  = br;
    ex_br_target = tgt;
    dram_busy    = busy;
    halt_clr     = hc;
  endtask

  // Inputs are set just after a rising edge; outputs are checked on the falling edge.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    int burst;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    #3;
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    repeat (BOOT_CYCLES + 1) step();
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0);
    repeat (3) step();
    drive(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step();

    drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    repeat (WAIT_MAX) step();
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    repeat (BOOT_CYCLES + 2) step();

    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      if (burst == 0 && $urandom_range(0, 99) < 10) burst = $urandom_range(1, WAIT_MAX + 4);
      drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 25, $urandom,
            burst != 0, $urandom_range(0, 99) < 25);
      if (burst != 0) burst--;
      step();
    end

    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    repeat (BOOT_CYCLES + 3) step();
    drive(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b0);
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    repeat (BOOT_CYCLES + WAIT_MAX - 1) step();
    drive(1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
